// File: rtl/gearbox_stream.sv
// Valid/ready width converter: IN-bit words are packed LSB-first into a bit buffer and drained as OUT-bit words.
// Define GEARBOX_FLUSH_EN to let a flush pulse drain a partial, zero-padded final word.
module gearbox_stream #(
    parameter  int IN  = 12,
    parameter  int OUT = 25,
    localparam int BUF = IN + 2*OUT,
    localparam int LW  = $clog2(BUF+1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IN-1:0]  in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [OUT-1:0] out_data,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic           flush,
    output logic [LW-1:0]  level
);

    logic [BUF-1:0] bit_buf;
    logic [LW-1:0]  cnt;
    logic           flush_pend;

    logic           in_fire, out_fire;
    logic [BUF-1:0] sh_buf, nxt_buf;
    logic [LW-1:0]  sh_cnt, nxt_cnt;

    // Handshake outputs depend on registered state only.
    assign in_ready  = (cnt <= LW'(BUF-IN)) && !flush_pend;
    assign out_valid = (cnt >= LW'(OUT)) || (flush_pend && (cnt != '0));
    assign out_data  = bit_buf[OUT-1:0];
    assign level     = cnt;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Pop first, then append the new word at the post-pop fill level.
    // Bits at and above cnt are always zero, so OR-ing the word in is safe.
    always_comb begin
        sh_buf  = bit_buf;
        sh_cnt  = cnt;
        if (out_fire) begin
            sh_buf = bit_buf >> OUT;
            sh_cnt = (cnt > LW'(OUT)) ? cnt - LW'(OUT) : '0;
        end
        nxt_buf = sh_buf;
        nxt_cnt = sh_cnt;
        if (in_fire) begin
            nxt_buf = sh_buf | (BUF'(in_data) << sh_cnt);
            nxt_cnt = sh_cnt + LW'(IN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_buf <= '0;
            cnt     <= '0;
        end else begin
            bit_buf <= nxt_buf;
            cnt     <= nxt_cnt;
        end
    end

`ifdef GEARBOX_FLUSH_EN
    // A flush seen with an empty buffer (after any same-cycle accept) never arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
        end else if (flush_pend) begin
            if (nxt_cnt == '0)
                flush_pend <= 1'b0;
        end else if (flush && (nxt_cnt != '0)) begin
            flush_pend <= 1'b1;
        end
    end
`else
    logic flush_unused;
    assign flush_unused = flush;
    assign flush_pend   = 1'b0;
`endif

endmodule

// File: tb/tb_gearbox_stream.sv
// Directed and scoreboarded checks of gearbox_stream in 12->25 and 25->12 configurations.
module tb_gearbox_stream;
    localparam int AI = 12, AO = 25, BI = 25, BO = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AI-1:0] a_in_data = '0;
    logic          a_in_valid = 1'b0, a_out_ready = 1'b0, a_flush = 1'b0;
    logic          a_in_ready, a_out_valid;
    logic [AO-1:0] a_out_data;
    logic [5:0]    a_level;

    logic [BI-1:0] b_in_data = '0;
    logic          b_in_valid = 1'b0, b_out_ready = 1'b0, b_flush = 1'b0;
    logic          b_in_ready, b_out_valid;
    logic [BO-1:0] b_out_data;
    logic [5:0]    b_level;

    gearbox_stream #(.IN(AI), .OUT(AO)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .flush(a_flush), .level(a_level));

    gearbox_stream #(.IN(BI), .OUT(BO)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .flush(b_flush), .level(b_level));

    int checks = 0, failures = 0;
    bit qa[$], qb[$];
    bit a_hold = 1'b0, b_hold = 1'b0;
    logic [AO-1:0] a_hold_data = '0;
    logic [BO-1:0] b_hold_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: checks state, drives inputs for the next edge, updates the model.
    task automatic step_a(input bit iv, input logic [AI-1:0] id, input bit ordy);
        logic [AO-1:0] w;
        if (a_hold) begin
            check("a_hold_valid", 64'(a_out_valid), 64'd1);
            check("a_hold_data", 64'(a_out_data), 64'(a_hold_data));
        end
        check("a_level", 64'(a_level), 64'(qa.size()));
        check("a_in_ready", 64'(a_in_ready), 64'(qa.size() <= BI*0 + 50));
        a_in_valid = iv; a_in_data = id; a_out_ready = ordy;
        if (a_out_valid && ordy) begin
            w = '0;
            for (int i = 0; i < AO; i++) if (qa.size() > 0) w[i] = qa.pop_front();
            check("a_data", 64'(a_out_data), 64'(w));
        end
        if (iv && a_in_ready) for (int i = 0; i < AI; i++) qa.push_back(id[i]);
        a_hold = a_out_valid && !ordy;
        a_hold_data = a_out_data;
        @(negedge clk);
    endtask

    task automatic step_b(input bit iv, input logic [BI-1:0] id, input bit ordy);
        logic [BO-1:0] w;
        if (b_hold) begin
            check("b_hold_valid", 64'(b_out_valid), 64'd1);
            check("b_hold_data", 64'(b_out_data), 64'(b_hold_data));
        end
        check("b_level", 64'(b_level), 64'(qb.size()));
        check("b_in_ready", 64'(b_in_ready), 64'(qb.size() <= 24));
        b_in_valid = iv; b_in_data = id; b_out_ready = ordy;
        if (b_out_valid && ordy) begin
            w = '0;
            for (int i = 0; i < BO; i++) if (qb.size() > 0) w[i] = qb.pop_front();
            check("b_data", 64'(b_out_data), 64'(w));
        end
        if (iv && b_in_ready) for (int i = 0; i < BI; i++) qb.push_back(id[i]);
        b_hold = b_out_valid && !ordy;
        b_hold_data = b_out_data;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        qa.delete(); qb.delete();
        a_hold = 1'b0; b_hold = 1'b0;
    endtask

    task automatic deser_seq(input string tag);
        step_a(1'b1, 12'h001, 1'b1);
        step_a(1'b1, 12'h002, 1'b1);
        step_a(1'b1, 12'h003, 1'b1);
        check({tag, "_valid"}, 64'(a_out_valid), 64'd1);
        check({tag, "_data"}, 64'(a_out_data), 64'h1002001);
        step_a(1'b0, 12'h000, 1'b1);
        check({tag, "_level"}, 64'(a_level), 64'd11);
        check({tag, "_rem"}, 64'(a_out_data), 64'd1);
        check({tag, "_nvalid"}, 64'(a_out_valid), 64'd0);
    endtask

    initial begin
        int sent, guard;
        #12;
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_level", 64'(a_level), 64'd0);
        check("rst_a_out_data", 64'(a_out_data), 64'd0);
        check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_level", 64'(b_level), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        deser_seq("deser");

        // Backpressure: fill from 11 bits until in_ready drops (11,23,35,47,59).
        guard = 0;
        while (a_in_ready && guard < 20) begin
            step_a(1'b1, AI'($urandom), 1'b0);
            guard++;
        end
        check("bp_timeout", 64'(guard < 20), 64'd1);
        check("bp_level", 64'(a_level), 64'd59);
        check("bp_in_ready", 64'(a_in_ready), 64'd0);
        for (int i = 0; i < 5; i++) step_a(1'b1, AI'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) step_a(1'b0, 12'h000, 1'b1);

        // Random 12->25 stream with random stalls on both sides.
        sent = 0; guard = 0;
        while (sent < 10000 && guard < 40000) begin
            bit iv, ordy;
            iv = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            if (iv && a_in_ready) sent++;
            step_a(iv, AI'($urandom), ordy);
            guard++;
        end
        check("a_rand_timeout", 64'(sent), 64'd10000);
        idle_inputs();

        // 25->12 at full rate: out_valid every cycle after the first accept.
        for (int i = 0; i < 300; i++) begin
            step_b(1'b1, BI'($urandom), 1'b1);
            check("b_full_rate", 64'(b_out_valid), 64'd1);
        end
        sent = 0; guard = 0;
        while (sent < 2000 && guard < 20000) begin
            bit iv, ordy;
            iv = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            if (iv && b_in_ready) sent++;
            step_b(iv, BI'($urandom), ordy);
            guard++;
        end
        check("b_rand_timeout", 64'(sent), 64'd2000);
        idle_inputs();

        // Flush behaviour on 12->25 with a single word 0xABC.
        do_reset();
        step_a(1'b1, 12'hABC, 1'b0);
        a_in_valid = 1'b0;
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
`ifdef GEARBOX_FLUSH_EN
        check("fl_valid", 64'(a_out_valid), 64'd1);
        check("fl_data", 64'(a_out_data), 64'h0000ABC);
        check("fl_in_ready", 64'(a_in_ready), 64'd0);
        check("fl_level", 64'(a_level), 64'd12);
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        qa.delete();
        check("fl_post_level", 64'(a_level), 64'd0);
        check("fl_post_in_ready", 64'(a_in_ready), 64'd1);
        check("fl_post_valid", 64'(a_out_valid), 64'd0);
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        check("fl_empty_in_ready", 64'(a_in_ready), 64'd1);
`else
        check("nofl_valid", 64'(a_out_valid), 64'd0);
        check("nofl_level", 64'(a_level), 64'd12);
        check("nofl_in_ready", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        check("nofl_valid2", 64'(a_out_valid), 64'd0);
`endif

        // Asynchronous reset mid-stream, then a clean replay.
        step_a(1'b1, 12'h5A5, 1'b0);
        step_a(1'b1, 12'h3C3, 1'b0);
        a_in_valid = 1'b0;
        check("pre_rst_level_nz", 64'(a_level != 0), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 64'(a_in_ready), 64'd1);
        check("arst_out_valid", 64'(a_out_valid), 64'd0);
        check("arst_level", 64'(a_level), 64'd0);
        check("arst_out_data", 64'(a_out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        qa.delete(); qb.delete();
        a_hold = 1'b0; b_hold = 1'b0;
        deser_seq("replay");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
